// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int DEFAULT_AW = 32;
    localparam int DEFAULT_DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } req_id_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between instruction and data requesters.
// ARB_RR_EN selects round-robin on ties; otherwise data has fixed priority.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic    i_req,
    input  logic    d_req,
`ifdef ARB_RR_EN
    input  req_id_t last_winner,
`endif
    output req_id_t winner,
    output logic    valid
);

    always_comb begin
        valid  = i_req | d_req;
        winner = REQ_I;
`ifdef ARB_RR_EN
        if (i_req && d_req) begin
            winner = (last_winner == REQ_I) ? REQ_D : REQ_I;
        end else if (d_req) begin
            winner = REQ_D;
        end
`else
        if (d_req) begin
            winner = REQ_D;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction fetch and data requests onto one synchronous SRAM port.
// Build option ARB_RR_EN: round-robin tie-break instead of data-first priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = DEFAULT_AW,
    parameter int DW = DEFAULT_DW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW/8-1:0] d_we,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            m_cs,
    output logic [AW-1:0]   m_addr,
    output logic [DW/8-1:0] m_we,
    output logic [DW-1:0]   m_wdata,
    input  logic [DW-1:0]   m_rdata
);

    state_t            state_reg;
    req_id_t           winner_reg;
    req_id_t           pick_winner;
    logic              pick_valid;
    logic              i_gnt_reg;
    logic              d_gnt_reg;
    logic              i_rvalid_reg;
    logic              d_rvalid_reg;
    logic              m_cs_reg;
    logic [AW-1:0]     m_addr_reg;
    logic [DW/8-1:0]   m_we_reg;
    logic [DW-1:0]     m_wdata_reg;
`ifdef ARB_RR_EN
    req_id_t           last_winner_reg;
`endif

    arb_pick u_pick (
        .i_req       (i_req),
        .d_req       (d_req),
`ifdef ARB_RR_EN
        .last_winner (last_winner_reg),
`endif
        .winner      (pick_winner),
        .valid       (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            winner_reg   <= REQ_I;
            i_gnt_reg    <= 1'b0;
            d_gnt_reg    <= 1'b0;
            i_rvalid_reg <= 1'b0;
            d_rvalid_reg <= 1'b0;
            m_cs_reg     <= 1'b0;
            m_addr_reg   <= '0;
            m_we_reg     <= '0;
            m_wdata_reg  <= '0;
`ifdef ARB_RR_EN
            last_winner_reg <= REQ_I;
`endif
        end else begin
            // Grant, rvalid, chip select and strobes are single-cycle pulses.
            i_gnt_reg    <= 1'b0;
            d_gnt_reg    <= 1'b0;
            i_rvalid_reg <= 1'b0;
            d_rvalid_reg <= 1'b0;
            m_cs_reg     <= 1'b0;
            m_we_reg     <= '0;
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        state_reg  <= ACCESS;
                        winner_reg <= pick_winner;
                        m_cs_reg   <= 1'b1;
`ifdef ARB_RR_EN
                        last_winner_reg <= pick_winner;
`endif
                        if (pick_winner == REQ_D) begin
                            d_gnt_reg   <= 1'b1;
                            m_addr_reg  <= d_addr;
                            m_we_reg    <= d_we;
                            m_wdata_reg <= d_wdata;
                        end else begin
                            i_gnt_reg   <= 1'b1;
                            m_addr_reg  <= i_addr;
                            m_wdata_reg <= '0;
                        end
                    end
                end
                ACCESS: begin
                    state_reg <= RESP;
                    if (winner_reg == REQ_D) begin
                        d_rvalid_reg <= 1'b1;
                    end else begin
                        i_rvalid_reg <= 1'b1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // SRAM data arrives the cycle after chip select, which is exactly the RESP cycle.
    assign i_rdata  = i_rvalid_reg ? m_rdata : '0;
    assign d_rdata  = d_rvalid_reg ? m_rdata : '0;
    assign i_gnt    = i_gnt_reg;
    assign d_gnt    = d_gnt_reg;
    assign i_rvalid = i_rvalid_reg;
    assign d_rvalid = d_rvalid_reg;
    assign m_cs     = m_cs_reg;
    assign m_addr   = m_addr_reg;
    assign m_we     = m_we_reg;
    assign m_wdata  = m_wdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, tie/overlap/reset sequences,
// and an rvalid scoreboard fed from a small SRAM model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_cs;
    logic [31:0] m_addr;
    logic [3:0]  m_we;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_we     (d_we),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_cs     (m_cs),
        .m_addr   (m_addr),
        .m_we     (m_we),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata)
    );

    // SRAM model: registered read of old contents, byte-strobed write.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[8'h10] <= 32'hDEADBEEF;
            mem[8'h30] <= 32'hCAFEF00D;
            m_rdata    <= 32'h0;
        end else if (m_cs) begin
            for (int b = 0; b < 4; b++) begin
                if (m_we[b]) mem[m_addr[7:0]][8*b +: 8] <= m_wdata[8*b +: 8];
            end
            m_rdata <= mem[m_addr[7:0]];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_d;
        bit          chk;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    typedef struct {
        bit          ireq;
        logic [31:0] iaddr;
        bit          dreq;
        logic [3:0]  dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        bit          exp_d;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_mwe;
        logic [31:0] exp_mwdata;
        bit          chk_rd;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: every rvalid pops the next expected completion.
    always @(negedge clk) begin
        if (rst_n) begin
            check("gnt_both", 32'(i_gnt & d_gnt), 32'h0);
            check("rvalid_both", 32'(i_rvalid & d_rvalid), 32'h0);
            if (!i_rvalid) check("i_rdata_idle", i_rdata, 32'h0);
            if (!d_rvalid) check("d_rdata_idle", d_rdata, 32'h0);
            if (i_rvalid || d_rvalid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rvalid", 32'(d_rvalid), 32'(i_rvalid) + 32'h2);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rvalid_port", 32'(d_rvalid), 32'(mon_e.is_d));
                    if (mon_e.chk) check("rdata", mon_e.is_d ? d_rdata : i_rdata, mon_e.data);
                    $display("txn cycle=%0d port=%s rdata=0x%08h", cyc, d_rvalid ? "D" : "I",
                             d_rvalid ? d_rdata : i_rdata);
                end
            end
        end
    end

    task automatic wait_gnt(output bit got, output bit is_d, output int at);
        got  = 1'b0;
        is_d = 1'b0;
        at   = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (i_gnt || d_gnt) begin
                got  = 1'b1;
                is_d = d_gnt;
                at   = cyc;
            end
        end
        if (!got) check("gnt_timeout", 32'h0, 32'h1);
    endtask

    task automatic push_exp(input bit is_d, input bit chk, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.chk  = chk;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        bit got;
        bit isd;
        int at;
        int c0;
        @(posedge clk);
        #1;
        i_req   = v.ireq;
        i_addr  = v.iaddr;
        d_req   = v.dreq;
        d_we    = v.dwe;
        d_addr  = v.daddr;
        d_wdata = v.dwdata;
        c0      = cyc;
        push_exp(v.exp_d, v.chk_rd, v.exp_rdata);
        wait_gnt(got, isd, at);
        if (got) begin
            check("gnt_latency", 32'(at - c0), 32'h1);
            check("gnt_port", 32'(isd), 32'(v.exp_d));
            check("m_cs_access", 32'(m_cs), 32'h1);
            check("m_addr", m_addr, v.exp_maddr);
            check("m_we", 32'(m_we), 32'(v.exp_mwe));
            if (v.exp_mwe != 4'h0) check("m_wdata", m_wdata, v.exp_mwdata);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        check("rvalid_t2", 32'(v.exp_d ? d_rvalid : i_rvalid), 32'h1);
        check("m_cs_resp", 32'(m_cs), 32'h0);
        check("m_we_resp", 32'(m_we), 32'h0);
    endtask

    initial begin
        bit          got;
        bit          isd;
        int          at;
        int          prev;
        logic [3:0]  tie_order;

        vecs[0] = '{1'b1, 32'h10, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0, 32'h10, 4'h0, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 32'h0,  1'b1, 4'hF, 32'h20, 32'h12345678, 1'b1, 32'h20, 4'hF, 32'h12345678, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 32'h0,  1'b1, 4'h0, 32'h20, 32'h0,        1'b1, 32'h20, 4'h0, 32'h0,        1'b1, 32'h12345678};
        vecs[3] = '{1'b1, 32'h20, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0, 32'h20, 4'h0, 32'h0,        1'b1, 32'h12345678};
        vecs[4] = '{1'b0, 32'h0,  1'b1, 4'h3, 32'h20, 32'hAAAA5555, 1'b1, 32'h20, 4'h3, 32'hAAAA5555, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 32'h0,  1'b1, 4'h0, 32'h20, 32'h0,        1'b1, 32'h20, 4'h0, 32'h0,        1'b1, 32'h12345555};

        rst_n   = 1'b0;
        i_req   = 1'b0;
        i_addr  = 32'h0;
        d_req   = 1'b0;
        d_addr  = 32'h0;
        d_we    = 4'h0;
        d_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_cs", 32'(m_cs), 32'h0);
        check("rst_m_addr", m_addr, 32'h0);
        check("rst_m_we", 32'(m_we), 32'h0);
        check("rst_m_wdata", m_wdata, 32'h0);
        check("rst_gnt", 32'({i_gnt, d_gnt}), 32'h0);
        check("rst_rvalid", 32'({i_rvalid, d_rvalid}), 32'h0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Both requesters held for four transactions from a fresh reset.
        do_reset();
`ifdef ARB_RR_EN
        tie_order = 4'b0101;
`else
        tie_order = 4'b1111;
`endif
        @(posedge clk);
        #1;
        i_req  = 1'b1;
        i_addr = 32'h10;
        d_req  = 1'b1;
        d_we   = 4'h0;
        d_addr = 32'h30;
        for (int k = 0; k < 4; k++) push_exp(tie_order[k], 1'b1, tie_order[k] ? 32'hCAFEF00D : 32'hDEADBEEF);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(got, isd, at);
            if (got) begin
                check("tie_port", 32'(isd), 32'(tie_order[k]));
                check("tie_m_addr", m_addr, tie_order[k] ? 32'h30 : 32'h10);
                if (k > 0) check("tie_spacing", 32'(at - prev), 32'h3);
                prev = at;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);

        // Data request raised while an instruction access is in flight.
        @(posedge clk);
        #1;
        i_req  = 1'b1;
        i_addr = 32'h10;
        push_exp(1'b0, 1'b1, 32'hDEADBEEF);
        wait_gnt(got, isd, at);
        check("ovl_first_port", 32'(isd), 32'h0);
        prev   = at;
        i_req  = 1'b0;
        d_req  = 1'b1;
        d_we   = 4'h0;
        d_addr = 32'h30;
        push_exp(1'b1, 1'b1, 32'hCAFEF00D);
        wait_gnt(got, isd, at);
        if (got) begin
            check("ovl_second_port", 32'(isd), 32'h1);
            check("ovl_spacing", 32'(at - prev), 32'h3);
        end
        d_req = 1'b0;
        @(negedge clk);

        // Reset pulled during ACCESS drops the transaction.
        @(posedge clk);
        #1;
        i_req  = 1'b1;
        i_addr = 32'h10;
        push_exp(1'b0, 1'b1, 32'hDEADBEEF);
        wait_gnt(got, isd, at);
        rst_n = 1'b0;
        i_req = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_m_cs", 32'(m_cs), 32'h0);
        check("midrst_gnt", 32'({i_gnt, d_gnt}), 32'h0);
        check("midrst_m_addr", m_addr, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_no_rvalid", 32'({i_rvalid, d_rvalid}), 32'h0);
        end
        run_vec(vecs[0]);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous SRAM between the CPU instruction-fetch port and the CPU data port. Each requester issues a req/gnt/rvalid transaction. The arbiter serialises the two requesters onto the memory port and routes read data back to the requester that issued the read. It sits between the multi-cycle CPU core and the unified memory macro.

## Interface
- AW, 32, address width
- DW, 32, data width (byte strobes = DW/8)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  instruction read request
- i_addr  in  AW  instruction address
- i_gnt  out  1  instruction grant pulse
- i_rvalid  out  1  instruction read data valid pulse
- i_rdata  out  DW  instruction read data
- d_req  in  1  data request
- d_addr  in  AW  data address
- d_we  in  DW/8  byte write strobes; 0 = read
- d_wdata  in  DW  data write value
- d_gnt  out  1  data grant pulse
- d_rvalid  out  1  data completion pulse; used for reads and writes
- d_rdata  out  DW  data read data
- m_cs  out  1  memory chip select
- m_addr  out  AW  memory address
- m_we  out  DW/8  memory byte write strobes
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data; valid the cycle after m_cs

## Operation
- FSM states:
  - IDLE: sample the requests and pick a winner. If there is a winner, go to ACCESS; else stay in IDLE.
  - ACCESS: unconditionally go to RESP.
  - RESP: unconditionally go to IDLE.
- Winner selection (see Configuration). A winning data request with d_we==0 is a read; any nonzero d_we is a write.
- ACCESS cycle:
  - m_cs=1.
  - m_addr, m_we and m_wdata come from the winner's inputs, registered at the IDLE→ACCESS edge.
  - m_we=0 for instruction accesses.
  - The winner's gnt=1; all other gnt=0.
- RESP cycle:
  - The winner's rvalid=1.
  - The winner's rdata is driven from m_rdata.
  - For data writes, d_rvalid=1 as a completion acknowledgement and d_rdata is don't-care.
  - m_cs=0 and m_we=0.
- Requester rules:
  - Hold req, addr, we and wdata stable until gnt is seen.
  - req may drop in the cycle after gnt.
  - A req still high in the next IDLE is treated as a new transaction.
- Exactly one requester is active per transaction. gnt and rvalid are never asserted on both ports in the same cycle.
- i_rdata and d_rdata are 0 outside their own RESP cycle.

## Timing
- Reset values:
  - State IDLE.
  - m_cs=0, m_addr=0, m_we=0, m_wdata=0.
  - i_gnt, d_gnt, i_rvalid, d_rvalid all 0.
  - rdata outputs 0.
  - last_winner = instruction.
- Request seen high in IDLE at cycle T:
  - gnt and m_cs are high in T+1.
  - rvalid is high in T+2.
  - The FSM is back in IDLE at T+3.
- Throughput: one access every 3 cycles; back-to-back requests are granted every 3 cycles.
- Requests arriving during ACCESS or RESP are not sampled until the next IDLE. There is no loss provided the requester holds req.
- Reset asserted mid-transaction:
  - The transaction is dropped and all outputs return to reset values immediately.
  - No rvalid is produced after reset deasserts.

## Configuration
- ARB_RR_EN defined: round-robin.
  - With both requests pending, grant the requester that is not last_winner.
  - last_winner updates on every grant.
  - After reset the first tie goes to data.
- ARB_RR_EN undefined: fixed priority, data over instruction. last_winner is not implemented.

## Structure
- Package mem_arb_pkg holds:
  - the state typedef (IDLE, ACCESS, RESP);
  - the requester id typedef (REQ_I, REQ_D);
  - the default AW and DW constants.
- Sub-module arb_pick is purely combinational. It takes i_req, d_req and last_winner and outputs the winner id plus a valid flag. It contains the ARB_RR_EN logic.

## Test plan
- Single instruction read: i_req=1, i_addr=0x10, memory holds 0xDEADBEEF at 0x10 → i_gnt and m_cs in T+1 with m_addr=0x10, m_we=0; i_rvalid=1 and i_rdata=0xDEADBEEF in T+2.
- Data write: d_we=0xF, d_addr=0x20, d_wdata=0x12345678 → m_we=0xF and m_wdata=0x12345678 in T+1; d_rvalid in T+2; a subsequent read of 0x20 returns 0x12345678.
- Simultaneous i_req and d_req held high for 4 transactions → RR build grants D,I,D,I; fixed build grants D,D,D,D.
- Request raised during ACCESS of another transaction → granted exactly 3 cycles after the prior grant, with no cycle where both gnt are high.
- rst_n pulled low during ACCESS → m_cs=0 and gnt=0 immediately; no rvalid after release; the next request completes normally.
